// File: rtl/hfrv_mem_pkg.sv
// hfrv_mem_pkg: shared types and constants for the hf-riscv memory arbiter.
package hfrv_mem_pkg;
    typedef enum logic {M0 = 1'b0, M1 = 1'b1} owner_t;

    localparam logic [3:0] WE_READ = 4'b0000;
    localparam logic [3:0] WE_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } mem_req_t;

    function automatic logic is_read(input logic [3:0] we);
        return we == WE_READ;
    endfunction
endpackage

// File: rtl/hfrv_rr_arb2.sv
// hfrv_rr_arb2: two-way round-robin grant with a bounded burst lock.
module hfrv_rr_arb2
    import hfrv_mem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_req0,
    input  logic   i_req1,
    output logic   o_gnt0,
    output logic   o_gnt1,
    output owner_t o_owner
);
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] r_burst_cnt;
    logic [CW-1:0] w_cnt_nxt;
    owner_t        r_last_owner;
    owner_t        w_owner;
    logic          w_any;
    logic          w_keep;

    // burst_cnt == 0 means the previous cycle was idle, so there is no owner to keep
    always_comb begin
        w_any     = reset_n & (i_req0 | i_req1);
        w_keep    = (r_burst_cnt != '0) && (r_burst_cnt < CW'(MAX_BURST));
        w_owner   = (i_req0 & i_req1) ? (w_keep ? r_last_owner : (r_last_owner == M0 ? M1 : M0))
                                      : (i_req1 ? M1 : M0);
        w_cnt_nxt = !w_any ? '0
                  : (w_owner == r_last_owner && r_burst_cnt != '0)
                      ? (r_burst_cnt == CW'(MAX_BURST) ? r_burst_cnt : r_burst_cnt + 1'b1)
                      : CW'(1);
    end

    assign o_gnt0  = w_any & (w_owner == M0);
    assign o_gnt1  = w_any & (w_owner == M1);
    assign o_owner = w_owner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_burst_cnt  <= '0;
            r_last_owner <= M1;
        end else begin
            r_burst_cnt <= w_cnt_nxt;
            if (w_any) r_last_owner <= w_owner;
        end
    end
endmodule

// File: rtl/hfrv_mem_arbiter.sv
// hfrv_mem_arbiter: shares one synchronous memory port between the CPU (m0) and a second master (m1).
module hfrv_mem_arbiter
    import hfrv_mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_we,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              stall,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_we,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_write,
    output logic [3:0]        mem_data_we,
    input  logic [DATA_W-1:0] mem_data_read
);
    logic              w_gnt0;
    logic              w_gnt1;
    owner_t            w_owner;
    logic              r_tag_vld;
    owner_t            r_tag_owner;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    hfrv_rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req0  (m0_req),
        .i_req1  (m1_req),
        .o_gnt0  (w_gnt0),
        .o_gnt1  (w_gnt1),
        .o_owner (w_owner)
    );

    assign m0_gnt         = w_gnt0;
    assign m1_gnt         = w_gnt1;
    assign stall          = m0_req & ~w_gnt0;
    assign mem_en         = w_gnt0 | w_gnt1;
    assign mem_addr       = w_gnt0 ? m0_addr  : w_gnt1 ? m1_addr  : '0;
    assign mem_data_write = w_gnt0 ? m0_wdata : w_gnt1 ? m1_wdata : '0;
    assign mem_data_we    = w_gnt0 ? m0_we    : w_gnt1 ? m1_we    : WE_READ;

    // read data arrives one cycle after the access; the tag steers it to its issuer
    assign m0_rvalid = r_tag_vld & (r_tag_owner == M0);
    assign m1_rvalid = r_tag_vld & (r_tag_owner == M1);
    assign m0_rdata  = m0_rvalid ? mem_data_read : r_m0_rdata;
    assign m1_rdata  = m1_rvalid ? mem_data_read : r_m1_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_vld   <= 1'b0;
            r_tag_owner <= M0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_tag_vld   <= mem_en & is_read(mem_data_we);
            r_tag_owner <= w_owner;
            if (m0_rvalid) r_m0_rdata <= mem_data_read;
            if (m1_rvalid) r_m1_rdata <= mem_data_read;
        end
    end
endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// tb_hfrv_mem_arbiter: directed scoreboard bench; instance 0 uses MAX_BURST=4, instance 1 MAX_BURST=1.
module tb_hfrv_mem_arbiter;
    import hfrv_mem_pkg::*;

    typedef struct {
        logic        own;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_we, m1_we;

    logic        g0 [2];
    logic        g1 [2];
    logic        rv0 [2];
    logic        rv1 [2];
    logic        st [2];
    logic        men [2];
    logic [31:0] rd0 [2];
    logic [31:0] rd1 [2];
    logic [31:0] maddr [2];
    logic [31:0] mwr [2];
    logic [3:0]  mwe [2];

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic [31:0] rd;
        always @(posedge clk)
            if (men[g] && mwe[g] == WE_READ) rd <= memf(maddr[g]);
        hfrv_mem_arbiter #(.MAX_BURST(g == 0 ? 4 : 1)) dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .m0_req         (m0_req),
            .m0_addr        (m0_addr),
            .m0_wdata       (m0_wdata),
            .m0_we          (m0_we),
            .m0_gnt         (g0[g]),
            .m0_rvalid      (rv0[g]),
            .m0_rdata       (rd0[g]),
            .stall          (st[g]),
            .m1_req         (m1_req),
            .m1_addr        (m1_addr),
            .m1_wdata       (m1_wdata),
            .m1_we          (m1_we),
            .m1_gnt         (g1[g]),
            .m1_rvalid      (rv1[g]),
            .m1_rdata       (rd1[g]),
            .mem_en         (men[g]),
            .mem_addr       (maddr[g]),
            .mem_data_write (mwr[g]),
            .mem_data_we    (mwe[g]),
            .mem_data_read  (rd)
        );
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string t);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, obs, exp);
        end
    endtask

    // one cycle: check the read due from the previous grant, then this cycle's grant
    task automatic step(input int d, input logic e0, input logic e1, input string t);
        exp_t x;
        logic v0, v1;
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
        x  = '{1'b0, 32'h0};
        if (q.size() > 0) begin
            x  = q.pop_front();
            v0 = (x.own == 1'b0);
            v1 = (x.own == 1'b1);
        end
        chk(32'(rv0[d]), 32'(v0), {t, " m0_rvalid"});
        chk(32'(rv1[d]), 32'(v1), {t, " m1_rvalid"});
        if (v0) chk(rd0[d], x.data, {t, " m0_rdata"});
        if (v1) chk(rd1[d], x.data, {t, " m1_rdata"});
        chk(32'(g0[d]), 32'(e0), {t, " m0_gnt"});
        chk(32'(g1[d]), 32'(e1), {t, " m1_gnt"});
        chk(32'(st[d]), 32'(m0_req & ~e0), {t, " stall"});
        chk(32'(men[d]), 32'(e0 | e1), {t, " mem_en"});
        if (e0 | e1) begin
            chk(maddr[d], e0 ? m0_addr : m1_addr, {t, " mem_addr"});
            chk(32'(mwe[d]), 32'(e0 ? m0_we : m1_we), {t, " mem_we"});
            if ((e0 ? m0_we : m1_we) != WE_READ)
                chk(mwr[d], e0 ? m0_wdata : m1_wdata, {t, " mem_wdata"});
        end
        if (e0 && m0_we == WE_READ) q.push_back('{1'b0, memf(m0_addr)});
        if (e1 && m1_we == WE_READ) q.push_back('{1'b1, memf(m1_addr)});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        reset_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        m0_req   = 1'b0;
        m1_req   = 1'b0;
        m0_addr  = '0;
        m1_addr  = '0;
        m0_wdata = '0;
        m1_wdata = '0;
        m0_we    = WE_READ;
        m1_we    = WE_READ;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(32'(g0[d] | g1[d] | men[d] | rv0[d] | rv1[d]), 32'h0, "reset ctl");
            chk(maddr[d], 32'h0, "reset mem_addr");
            chk(mwr[d], 32'h0, "reset mem_wdata");
            chk(32'(mwe[d]), 32'h0, "reset mem_we");
        end
        @(posedge clk);
        #1;
        // 1: first access straight out of reset
        reset_n = 1'b1;
        m0_req  = 1'b1;
        m0_addr = 32'h100;
        step(0, 1'b1, 1'b0, "t1 grant");
        m0_req = 1'b0;
        step(0, 1'b0, 1'b0, "t1 rdata");

        // 2: contention with burst lock of 4
        do_reset();
        m0_req  = 1'b1;
        m1_req  = 1'b1;
        m0_addr = 32'h10;
        m1_addr = 32'h8000;
        for (int i = 0; i < 12; i++) begin
            step(0, i < 4 || i >= 8, i >= 4 && i < 8, $sformatf("t2 burst%0d", i));
            if (i < 4 || i >= 8) m0_addr += 4;
            else m1_addr += 4;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        step(0, 1'b0, 1'b0, "t2 drain");

        // 3: lone m1 never locked out, then m0 gets in
        m1_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(0, 1'b0, 1'b1, $sformatf("t3 m1only%0d", i));
            m1_addr += 4;
        end
        m0_req = 1'b1;
        step(0, 1'b1, 1'b0, "t3 m0 in");
        m0_req = 1'b0;
        m1_req = 1'b0;
        step(0, 1'b0, 1'b0, "t3 drain");

        // 4: partial write, no read data must follow
        m0_req   = 1'b1;
        m0_addr  = 32'h200;
        m0_wdata = 32'hDEADBEEF;
        m0_we    = 4'b0011;
        step(0, 1'b1, 1'b0, "t4 write");
        m0_req = 1'b0;
        m0_we  = WE_READ;
        step(0, 1'b0, 1'b0, "t4 no rvalid");

        // 5: reset while an m1 read is in flight
        m1_req  = 1'b1;
        m1_addr = 32'h300;
        step(0, 1'b0, 1'b1, "t5 m1 read");
        m1_req  = 1'b0;
        reset_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk(32'(rv1[0]), 32'h0, "t5 m1_rvalid killed");
        chk(32'(rv0[0]), 32'h0, "t5 m0_rvalid");
        chk(rd1[0], 32'h0, "t5 m1_rdata reset");
        chk(32'(men[0]), 32'h0, "t5 mem_en reset");
        chk(maddr[0], 32'h0, "t5 mem_addr reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m0_req  = 1'b1;
        m1_req  = 1'b1;
        step(0, 1'b1, 1'b0, "t5 first tie");
        m0_req = 1'b0;
        m1_req = 1'b0;
        step(0, 1'b0, 1'b0, "t5 drain");

        // 6: MAX_BURST=1 strict alternation, m0 mixing reads and writes
        do_reset();
        m0_req   = 1'b1;
        m1_req   = 1'b1;
        m0_addr  = 32'h400;
        m1_addr  = 32'h500;
        m0_wdata = 32'hCAFE0000;
        m0_we    = WE_READ;
        for (int i = 0; i < 8; i++) begin
            step(1, i % 2 == 0, i % 2 == 1, $sformatf("t6 alt%0d", i));
            if (i % 2 == 0) begin
                m0_we    = (m0_we == WE_READ) ? WE_WORD : WE_READ;
                m0_addr += 4;
                m0_wdata += 1;
            end else m1_addr += 4;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        step(1, 1'b0, 1'b0, "t6 drain");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/hfrv_mem_arbiter.md
Name: hfrv_mem_arbiter

Overview:
- Two-master arbiter sharing the single synchronous memory port of the hf-riscv platform.
- Master 0 is the CPU. Master 1 is a secondary requester, such as a DMA engine or a testbench program loader.
- Round-robin arbitration with a bounded burst lock. Generates the CPU stall, and routes read data back to the master that issued the read.
- Sits between the cpu/driver side and the memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 to match 4-bit byte enables.
- MAX_BURST, 4, max consecutive grants to one master while the other is requesting; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m0_req  in  1  CPU access request.
- m0_addr  in  ADDR_W  CPU address.
- m0_wdata  in  DATA_W  CPU write data.
- m0_we  in  4  CPU byte write enables; 0 = read.
- m0_gnt  out  1  CPU access accepted this cycle.
- m0_rvalid  out  1  CPU read data valid.
- m0_rdata  out  DATA_W  CPU read data.
- stall  out  1  CPU stall = m0_req & ~m0_gnt.
- m1_req, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rvalid, m1_rdata: same as the m0_* ports, for master 1.
- mem_en  out  1  memory access strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_data_write  out  DATA_W  memory write data.
- mem_data_we  out  4  memory byte enables.
- mem_data_read  in  DATA_W  memory read data, valid one cycle after the access.

Behaviour:
- Reset (async assert, sync deassert assumed upstream), all registers cleared:
  - gnt, rvalid, mem_en and mem_data_we = 0.
  - mem_addr and mem_data_write = 0.
  - last_owner = 1, so m0 wins the first tie.
  - burst_cnt = 0, read tag pipeline invalid.
- Arbitration is combinational within cycle T from the req inputs and registered state. Exactly one gnt at most per cycle.
- Grant rules, in order:
  - Neither req: no grant, mem_en=0, mem_data_we=0. burst_cnt clears, last_owner holds.
  - Only one req: that master is granted, regardless of burst_cnt.
  - Both req, and the previous-cycle owner still requesting with burst_cnt < MAX_BURST: previous owner keeps the grant.
  - Both req otherwise: grant goes to the master != last_owner (round-robin).
- burst_cnt:
  - Increments on each consecutive grant to the same master, saturating at MAX_BURST.
  - Resets to 1 when ownership changes or after an idle cycle.
  - With MAX_BURST=1 the arbiter strictly alternates under contention.
- last_owner updates to the granted master on every grant.
- Datapath in grant cycle T:
  - mem_en=1.
  - mem_addr, mem_data_write and mem_data_we are muxed from the granted master, combinationally in the same cycle.
- Reads (we==0), issued at T:
  - Register a tag (valid + owner id).
  - At T+1, assert rvalid for exactly one cycle on the owning master only.
  - rdata = mem_data_read at T+1.
  - The non-owning master's rdata holds its last value.
- Writes (we!=0) never produce rvalid.
- Back-to-back reads by alternating masters pipeline at one access per cycle. Each rvalid is routed by its own tag.
- Requester rule: a master holds addr, wdata and we stable while req=1 and gnt=0. A transfer completes in the cycle req & gnt.
- stall is purely combinational, so the CPU freezes in the same cycle it loses arbitration.
- Reset asserted mid-operation:
  - Any in-flight read tag is discarded; no rvalid after reset.
  - Outputs return to their reset values immediately (asynchronously).

Decomposition:
- Package hfrv_mem_pkg holds:
  - typedef owner_t (1-bit enum M0, M1).
  - constants WE_READ = 4'b0000 and WE_WORD = 4'b1111.
  - struct mem_req_t {addr, wdata, we}.
- One natural sub-module: hfrv_rr_arb2, the grant logic plus last_owner and burst_cnt. The top level handles datapath muxing, the read tag pipeline and stall.

Test Plan:
1. Reset release with m0_req=1 read at 0x100 -> m0_gnt=1 same cycle, mem_addr=0x100; m0_rvalid=1 next cycle with m0_rdata = memory word; stall=0 throughout.
2. Both requesting continuous reads, MAX_BURST=4 -> grant sequence M0×4, M1×4, M0×4; stall=1 exactly during M1 windows; every rvalid lands on the issuing master.
3. Only m1_req, held for 10 cycles -> m1_gnt every cycle (no lock-out); then m0_req rises -> M0 granted within ≤ MAX_BURST cycles.
4. m0 write we=4'b0011 to 0x200, data 0xDEADBEEF, while m1 idle -> mem_data_we=4'b0011, mem_data_write=0xDEADBEEF; no rvalid on either master.
5. m1 read granted, reset_n pulsed low the next cycle -> m1_rvalid stays 0; after release all outputs are at reset values and the first tie goes to M0.
6. MAX_BURST=1, alternating contention with read/write mix -> strict M0/M1 alternation; rvalid only for reads, each one cycle after its grant.
